// File: rtl/gpu_muldiv_sequencer.sv
// Iterative multiply/divide unit with private HI/LO registers.
// One shift-add or restoring-divide step per clock; MTHI/MTLO served when not iterating.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO accepted
// RUN   | iterating, WIDTH cycles; busy high
// DONE  | result visible in HI/LO for one cycle; start or MTHI/MTLO accepted
module gpu_muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      count;
    logic               is_div, neg_res, neg_rem, dz;
    logic [WIDTH-1:0]   opnd, hi_q, lo_q;
    logic [2*WIDTH-1:0] acc, acc_nxt;

    logic               signed_op, a_neg, b_neg, accept, last_iter, fits;
    logic [WIDTH-1:0]   a_mag, b_mag, quo, rem, res_hi, res_lo;
    logic [WIDTH:0]     mul_sum, div_trial, div_diff;
    logic [2*WIDTH-1:0] prod;

    assign signed_op = ~op[0];
    assign a_neg     = signed_op & a_in[WIDTH-1];
    assign b_neg     = signed_op & b_in[WIDTH-1];
    assign a_mag     = a_neg ? -a_in : a_in;
    assign b_mag     = b_neg ? -b_in : b_in;
    assign accept    = start && (state != RUN);
    assign last_iter = (state == RUN) && (count == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (count == CW'(1)) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // acc holds {partial product, multiplier} for multiply, {remainder, dividend/quotient} for divide
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_trial - {1'b0, opnd};
        fits      = (div_trial >= {1'b0, opnd});
        if (is_div)
            acc_nxt = {(fits ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]), acc[WIDTH-2:0], fits};
        else
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end

    // A zero divisor leaves remainder = |a| and quotient = all ones, so HI = a after sign fix-up
    always_comb begin
        prod = neg_res ? -acc_nxt : acc_nxt;
        quo  = acc_nxt[WIDTH-1:0];
        rem  = acc_nxt[2*WIDTH-1:WIDTH];
        if (is_div) begin
            res_lo = dz ? '1 : (neg_res ? -quo : quo);
            res_hi = neg_rem ? -rem : rem;
        end else begin
            res_lo = prod[WIDTH-1:0];
            res_hi = prod[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q    <= '0;
            lo_q    <= '0;
            acc     <= '0;
            opnd    <= '0;
            count   <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
        end else begin
            if (state != RUN) begin
                if (mthi) hi_q <= wdata;
                if (mtlo) lo_q <= wdata;
            end
            if (accept) begin
                is_div  <= op[1];
                neg_res <= a_neg ^ b_neg;
                neg_rem <= a_neg;
                dz      <= op[1] && (b_in == '0);
                opnd    <= op[1] ? b_mag : a_mag;
                acc     <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                count   <= CW'(WIDTH);
            end else if (state == RUN) begin
                acc   <= acc_nxt;
                count <= count - CW'(1);
                if (last_iter) begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
            end
        end
    end

    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign div_zero = (state == DONE) && dz;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

endmodule
